// File: rtl/tick_debounce_repeat.sv
// Multi-channel pushbutton conditioner: 2-FF sync, tick-based debounce,
// press/release pulses and tick-timed auto-repeat while a button is held.
module tick_debounce_repeat #(
  parameter int unsigned NBTN         = 4,
  parameter int unsigned STABLE       = 4,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release
);

  localparam int unsigned CW   = $clog2(STABLE + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] ST_LAST = CW'(STABLE - 1);
  localparam logic [RW-1:0] RD_LAST = RW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [NBTN-1:0] sync1_q, sync2_q;
  logic [NBTN-1:0] level_d, press_d, release_d;
  logic [NBTN-1:0] rise_c, fall_c;
  logic [CW-1:0]   cnt_q   [NBTN];
  logic [CW-1:0]   cnt_d   [NBTN];
  logic [1:0]      state_q [NBTN];
  logic [1:0]      state_d [NBTN];
  logic [RW-1:0]   rcnt_q  [NBTN];
  logic [RW-1:0]   rcnt_d  [NBTN];

  // State registers; everything clears on a synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= S_IDLE;
        rcnt_q[i]  <= '0;
      end
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      for (int i = 0; i < int'(NBTN); i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  // Debounce, edge detection and repeat sequencing per channel.
  always_comb begin
    level_d   = btn_level;
    press_d   = '0;
    release_d = '0;
    rise_c    = '0;
    fall_c    = '0;
    for (int i = 0; i < int'(NBTN); i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];

      if (sync2_q[i] == btn_level[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == ST_LAST) begin
          level_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
          rise_c[i]  = sync2_q[i];
          fall_c[i]  = !sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      case (state_q[i])
        S_IDLE: begin
          if (rise_c[i]) begin
            press_d[i] = 1'b1;
            rcnt_d[i]  = '0;
            state_d[i] = (REPEAT_DELAY == 0) ? S_HOLD : S_DELAY;
          end
        end
        S_DELAY: begin
          if (tick) begin
            if (rcnt_q[i] == RD_LAST) begin
              press_d[i] = 1'b1;
              rcnt_d[i]  = '0;
              state_d[i] = S_REPEAT;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
          end
        end
        S_REPEAT: begin
          if (tick) begin
            if (rcnt_q[i] == RR_LAST) begin
              press_d[i] = 1'b1;
              rcnt_d[i]  = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase

      // A debounced fall overrides any repeat expiring on the same edge.
      if (fall_c[i]) begin
        release_d[i] = 1'b1;
        press_d[i]   = 1'b0;
        rcnt_d[i]    = '0;
        state_d[i]   = S_IDLE;
      end
    end
  end

endmodule

// File: doc/tick_debounce_repeat.md
Name: tick_debounce_repeat

Overview:
Multi-channel pushbutton conditioner that consumes the periodic one-clock strobe from the clock divider. All timing is counted in divider ticks rather than clocks. It synchronises raw pad inputs, debounces them, and emits clean levels, press/release pulses, and auto-repeat press pulses while a button is held. The outputs feed the game/control logic downstream.

Parameters:
NBTN, 4, number of independent button channels
STABLE, 4, consecutive ticks an input must differ from the debounced level before the level flips (>=1)
REPEAT_DELAY, 16, ticks from the initial press to the first auto-repeat pulse; 0 disables auto-repeat
REPEAT_RATE, 4, ticks between later auto-repeat pulses (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock, synchronous, active-low (sampled only on posedge clk)
tick  input  1  divider strobe; high for one clock per period, may be held high continuously (N=1)
btn_raw  input  NBTN  asynchronous raw button inputs, active-high
btn_level  output  NBTN  debounced level, registered
btn_press  output  NBTN  one-clock pulse on the debounced rising edge and on each auto-repeat
btn_release  output  NBTN  one-clock pulse on the debounced falling edge

Behaviour:
- Reset (rst_n low at a posedge): synchroniser flops, stability counters, repeat counters, and all outputs go to 0. Every FSM goes to IDLE. Reset mid-operation behaves the same way, and no pulse is emitted on the reset edge or the first edge after reset.
- Synchroniser: 2-FF per channel. sync[i] follows btn_raw[i] after 2 clock edges.
- Stability counter per channel, width $clog2(STABLE+1):
  - Any clock with sync==btn_level: cnt<=0, independent of tick. A glitch restarts the count.
  - tick and sync!=btn_level and cnt<STABLE-1: cnt<=cnt+1.
  - tick and sync!=btn_level and cnt==STABLE-1: btn_level<=sync, cnt<=0.
  - Clocks without tick leave cnt unchanged.
- Edge pulses: btn_press or btn_release is registered on the same edge that btn_level flips. The pulse is therefore high exactly during the first cycle in which the new level is visible. Both outputs clear on the next edge unless a new event occurs.
- Repeat FSM per channel, counter width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1):
  - IDLE: on the level rise, go to DELAY with rcnt=0. If REPEAT_DELAY==0, go to HOLD instead.
  - DELAY: on tick, rcnt++. On the tick where rcnt==REPEAT_DELAY-1, pulse btn_press, set rcnt=0, go to REPEAT.
  - REPEAT: on the tick where rcnt==REPEAT_RATE-1, pulse btn_press and set rcnt=0. Otherwise, on tick, rcnt++.
  - HOLD: no repeat.
  - From any non-IDLE state, a level fall goes to IDLE, pulses btn_release, and clears rcnt.
- Counting start: the tick on the same edge as the level rise is not counted by the repeat counter. The first auto-repeat therefore occurs on the REPEAT_DELAY-th tick after the press edge.
- Simultaneous release and repeat on the same edge: release wins and btn_press stays 0.
- Channels are fully independent. Any combination of channels may pulse on the same edge.
- tick held high continuously: all tick counts become clock counts, with no skipped or double counts.
- No combinational path from btn_raw or tick to any output.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with btn_raw=4'hF and tick=1 -> all outputs 0. After release, btn_level[3:0] rises on the edge of the 4th tick following sync (STABLE=4), with btn_press=4'hF for exactly 1 clock.
- Bounce: tick every 8 clocks, channel 0 toggling every 10 clocks for 100 clocks, then stable at 1 -> no level change during bouncing. btn_level[0] rises on the 4th tick after the final stable edge reaches sync, with exactly one press pulse.
- Auto-repeat: tick every 2 clocks, hold channel 1 for 40 ticks after the press -> press pulses at press edge, then ticks +16, +20, +24, +28, +32, +36, +40 (8 pulses total). Release after debounce -> one btn_release pulse, no further presses.
- Release vs repeat: arrange the debounced fall on the same edge as the REPEAT_RATE expiry -> btn_release=1, btn_press=0 on that edge, FSM in IDLE.
- Continuous tick (tick=1), REPEAT_DELAY=0 instance: press channel 2 -> level rises 2+4 clocks after raw (sync + STABLE), single press pulse, no repeats over 100 clocks.
- Mid-operation reset: assert rst_n=0 for 1 clock while channel 3 is in REPEAT with rcnt=2 -> next cycle all outputs 0. With the raw input still held, a fresh press occurs after sync plus 4 ticks, and the first repeat occurs 16 ticks after that.
